// File: rtl/converter_16_8_pipe_pkg.sv
// rtl/converter_16_8_pipe_pkg.sv - shared widths, result type and saturation helper
package conv_pkg;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 8;
    localparam int ABS_W   = IN_W + 1;
    localparam int MAG_MAX = (1 << OUT_W) - 1;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] mag;
    } sat_mag_t;

    // Clip an absolute value to the output magnitude range and flag the clip.
    function automatic sat_mag_t sat_mag(input logic [ABS_W-1:0] abs);
        sat_mag_t r;
        if (abs > ABS_W'(MAG_MAX)) begin
            r.sat = 1'b1;
            r.mag = '1;
        end else begin
            r.sat = 1'b0;
            r.mag = abs[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/converter_16_8_pipe_if.sv
// rtl/converter_16_8_pipe_if.sv - input and output handshake bundle for the converter
interface converter_16_8_pipe_if
    import conv_pkg::*;
#(
    parameter int DW = conv_pkg::IN_W,
    parameter int MW = conv_pkg::OUT_W
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [MW-1:0] out_mag;
    logic          out_sat;

    // Converter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag, out_sat
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, out_sat
    );

endinterface

// File: rtl/converter_16_8_pipe_split.sv
// rtl/converter_16_8_pipe_split.sv - two's-complement to sign plus widened absolute value
module sign_mag_split #(
    parameter int IN_W = 16
) (
    input  logic [IN_W-1:0] data_i,
    output logic            sign_o,
    output logic [IN_W:0]   abs_o
);

    logic [IN_W:0] ext_w;

    // One extra bit so the most negative input negates without wrapping.
    assign ext_w  = {data_i[IN_W-1], data_i};
    assign sign_o = data_i[IN_W-1];
    assign abs_o  = sign_o ? (~ext_w + (IN_W+1)'(1)) : ext_w;

endmodule

// File: rtl/converter_16_8_pipe.sv
// rtl/converter_16_8_pipe.sv - 2-stage 16-bit to sign/8-bit magnitude converter with clip counter
module converter_16_8_pipe
    import conv_pkg::*;
#(
    parameter int IN_W  = conv_pkg::IN_W,
    parameter int OUT_W = conv_pkg::OUT_W,
    parameter int CNT_W = conv_pkg::CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    converter_16_8_pipe_if.slave        bus,
    input  logic                        sat_clr,
    output logic [CNT_W-1:0]            sat_count
);

    logic             sign_w;
    logic [IN_W:0]    abs_w;
    sat_mag_t         sm_w;

    logic             in_fire;
    logic             out_fire;
    logic             stage2_load;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q;
    logic [IN_W:0]    s1_abs_q;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_sign_q;
    logic [OUT_W-1:0] s2_mag_q;
    logic             s2_sat_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    sign_mag_split #(
        .IN_W (IN_W)
    ) u_split (
        .data_i (bus.in_data),
        .sign_o (sign_w),
        .abs_o  (abs_w)
    );

    assign sm_w = sat_mag(s1_abs_q);

    // Each stage advances when empty or when its contents leave this cycle.
    assign stage2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid_q || stage2_load;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = s2_valid_q && bus.out_ready;

    // Next-state valid bits and clip counter; clear beats a counted transfer.
    always_comb begin
        s1_valid_d = in_fire || (s1_valid_q && !stage2_load);
        s2_valid_d = stage2_load || (s2_valid_q && !out_fire);
        cnt_d      = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (out_fire && s2_sat_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage 1: capture sign and absolute value of the accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_abs_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_sign_q <= sign_w;
                s1_abs_q  <= abs_w;
            end
        end
    end

    // Stage 2: saturate the magnitude and hold it until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_mag_q   <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (stage2_load) begin
                s2_sign_q <= s1_sign_q;
                s2_mag_q  <= sm_w.mag;
                s2_sat_q  <= sm_w.sat;
            end
        end
    end

    // Saturating count of clipped results delivered downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_mag   = s2_mag_q;
    assign bus.out_sat   = s2_sat_q;
    assign sat_count     = cnt_q;

endmodule

// File: tb/tb_converter_16_8_pipe.sv
// tb/tb_converter_16_8_pipe.sv - scoreboard bench for converter_16_8_pipe
module tb_converter_16_8_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sat_clr = 1'b0;
    logic [7:0] sat_count;

    converter_16_8_pipe_if bus ();

    converter_16_8_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sign;
        int mag;
        bit sat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    exp_t exp_q[$];
    int   in_cyc[$];
    int   out_cyc[$];
    bit   rand_run = 0;
    bit   bp_done = 0;
    bit   stall_prev = 0;
    int   prev_fields = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ref_model(input logic [15:0] d);
        exp_t e;
        int   v;
        int   a;
        v      = int'($signed(d));
        a      = (v < 0) ? -v : v;
        e.sign = (v < 0);
        e.sat  = (a > 255);
        e.mag  = e.sat ? 255 : a;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for data %h", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Stimulus side of the scoreboard: every accepted input queues its expected result.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_model(bus.in_data));
            in_cyc.push_back(cyc);
        end
    end

    // Monitor: compare delivered results, output stability and the clip counter.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   fire;
        bit   exp_sat;
        if (rst_n) begin
            check("sat_count", int'(sat_count), model_cnt);
            if (stall_prev) begin
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_fields", int'({bus.out_sign, bus.out_sat, bus.out_mag}), prev_fields);
            end
            fire    = bus.out_valid && bus.out_ready;
            exp_sat = 0;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: mag %0d with empty scoreboard", bus.out_mag);
                    exp_sat = bus.out_sat;
                end else begin
                    e = exp_q.pop_front();
                    check("out_sign", int'(bus.out_sign), int'(e.sign));
                    check("out_mag", int'(bus.out_mag), e.mag);
                    check("out_sat", int'(bus.out_sat), int'(e.sat));
                    exp_sat = e.sat;
                end
                out_cyc.push_back(cyc);
            end
            if (sat_clr) model_cnt = 0;
            else if (fire && exp_sat && model_cnt < 255) model_cnt++;
            stall_prev  = bus.out_valid && !bus.out_ready;
            prev_fields = int'({bus.out_sign, bus.out_sat, bus.out_mag});
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [15:0] corner [10];

    initial begin
        corner = '{16'h0000, 16'h00FF, 16'h0100, 16'hFF01, 16'hFF00,
                   16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'hFEFF};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        tick(3);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sign", int'(bus.out_sign), 0);
        check("rst_out_mag", int'(bus.out_mag), 0);
        check("rst_out_sat", int'(bus.out_sat), 0);
        check("rst_sat_count", int'(sat_count), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        tick(1);

        // Single item and its latency
        in_cyc.delete();
        out_cyc.delete();
        send(16'h0007);
        tick(4);
        check("lat_count", out_cyc.size(), 1);
        if (out_cyc.size() == 1 && in_cyc.size() == 1)
            check("latency", out_cyc[0] - in_cyc[0], 2);

        // Back-to-back with no bubbles
        in_cyc.delete();
        out_cyc.delete();
        send(16'hFFF9);
        send(16'h0000);
        send(16'h00FF);
        tick(4);
        check("b2b_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3)
            check("b2b_no_bubble", out_cyc[2] - out_cyc[0], 2);

        // Saturation cases
        send(16'h0100);
        send(16'h8000);
        send(16'hFF01);
        tick(4);
        check("sat_count_two", int'(sat_count), 2);

        // Randomized traffic with random backpressure
        rand_run = 1;
        fork
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) tick(gap);
            if ($urandom_range(0, 3) == 0) send(corner[$urandom_range(0, 9)]);
            else send(16'($urandom));
        end
        rand_run = 0;
        tick(2);
        bus.out_ready = 1'b1;
        tick(6);
        check("rand_drained", exp_q.size(), 0);

        // Backpressure: only two items fit while the output is stalled
        bus.out_ready = 1'b0;
        begin
            int n0;
            n0 = in_cyc.size();
            bp_done = 0;
            fork
                begin
                    for (int i = 1; i <= 4; i++) send(16'(i));
                    bp_done = 1;
                end
            join_none
            repeat (6) @(negedge clk);
            check("bp_accepted", in_cyc.size() - n0, 2);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_out_mag", int'(bus.out_mag), 1);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            for (int n = 0; n < 100 && !bp_done; n++) tick(1);
            check("bp_done", int'(bp_done), 1);
            tick(4);
            check("bp_drained", exp_q.size(), 0);
        end

        // Counter saturates at its maximum
        for (int i = 0; i < 260; i++) send(16'h8000);
        tick(4);
        check("cnt_limit", int'(sat_count), 255);

        // Clear coinciding with a counted transfer wins
        bus.out_ready = 1'b0;
        send(16'h0100);
        tick(3);
        sat_clr       = 1'b1;
        bus.out_ready = 1'b1;
        tick(1);
        sat_clr = 1'b0;
        check("cnt_clr_prio", int'(sat_count), 0);

        // Reset with both stages full
        send(16'h0200);
        tick(4);
        check("cnt_pre_reset", int'(sat_count), 1);
        bus.out_ready = 1'b0;
        send(16'h0001);
        send(16'h0002);
        tick(2);
        check("rst_full_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(bus.out_valid), 0);
        check("async_rst_cnt", int'(sat_count), 0);
        exp_q.delete();
        model_cnt = 0;
        tick(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", int'(bus.out_valid), 0);
        end
        tick(1);
        send(16'hFF80);
        tick(4);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
